// File: rtl/cpu_pkg.sv
// Shared types and constants for the LEGv8 branch and flag path.
package cpu_pkg;

    typedef enum logic [2:0] {
        BR_NONE   = 3'd0,
        BR_UNCOND = 3'd1,
        BR_CBZ    = 3'd2,
        BR_CBNZ   = 3'd3,
        BR_BCOND  = 3'd4
    } br_type_t;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_HS = 4'd2;
    localparam logic [3:0] COND_LO = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/flag_branch_unit_cond_eval.sv
// LEGv8 condition-code evaluator: decides whether cond holds for an NZCV value.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       taken
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    // Map each condition code onto its flag expression; codes 14 and 15 always hold.
    always_comb begin
        taken = 1'b1;
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = ~z;
            COND_HS: taken = c;
            COND_LO: taken = ~c;
            COND_MI: taken = n;
            COND_PL: taken = ~n;
            COND_VS: taken = v;
            COND_VC: taken = ~v;
            COND_HI: taken = c & ~z;
            COND_LS: taken = ~c | z;
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = ~z & (n == v);
            COND_LE: taken = z | (n != v);
            default: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// NZCV flag register, EX->ID flag forwarding, ID-stage branch resolution
// and the post-branch squash window.
module flag_branch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH        = 64,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_set_flags,
    input  logic [3:0]       ex_flags,
    input  logic             id_valid,
    input  logic [2:0]       id_br_type,
    input  logic [3:0]       id_cond,
    input  logic [WIDTH-1:0] id_operand,
    input  logic             stall,
    output logic [3:0]       flags,
    output logic             take_branch,
    output logic             squash
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] counter;
    logic       ex_writes;
    logic [3:0] eff_flags;
    logic       cond_taken;
    logic       op_zero;
    logic       br_taken;

    assign ex_writes = ex_valid & ex_set_flags;
    assign eff_flags = ex_writes ? ex_flags : flags;
    assign op_zero   = ~|id_operand;

    cond_eval u_cond_eval (
        .cond  (id_cond),
        .nzcv  (eff_flags),
        .taken (cond_taken)
    );

    // Raw branch outcome from the branch kind, before pipeline qualification.
    always_comb begin
        br_taken = 1'b0;
        case (id_br_type)
            BR_NONE:   br_taken = 1'b0;
            BR_UNCOND: br_taken = 1'b1;
            BR_CBZ:    br_taken = op_zero;
            BR_CBNZ:   br_taken = ~op_zero;
            BR_BCOND:  br_taken = cond_taken;
            default:   br_taken = 1'b0;
        endcase
    end

    // Wrong-path branches during FLUSH and stalled branches never redirect.
    assign take_branch = ~reset & id_valid & ~stall & (state == IDLE) & br_taken;

    // Architectural flag register, written by flag-setting EX instructions.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= '0;
        end else if (ex_writes && !stall) begin
            flags <= ex_flags;
        end
    end

    // Squash window: FLUSH_CYCLES cycles of squash after a taken branch, frozen by stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            squash  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_branch) begin
                        state   <= FLUSH;
                        counter <= 2'(FLUSH_CYCLES - 1);
                        squash  <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (!stall) begin
                        if (counter == '0) begin
                            state  <= IDLE;
                            squash <= 1'b0;
                        end else begin
                            counter <= counter - 2'd1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    squash <= 1'b0;
                end
            endcase
        end
    end

endmodule
